// File: rtl/pipe_stage_elastic_pkg.sv
// Shared definitions for the elastic pipeline stage.
//   SKID_DEPTH   number of entries held when the skid buffer is enabled
//   count_t      occupancy count (0..SKID_DEPTH)
//   count_next   occupancy after one cycle of accept/transfer
package pipe_stage_elastic_pkg;

  localparam int SKID_DEPTH = 2;

  typedef logic [1:0] count_t;

  function automatic count_t count_next(count_t cnt, logic inc, logic dec);
    return cnt + count_t'(inc) - count_t'(dec);
  endfunction

endpackage

// File: rtl/pipe_stage_elastic_entry_reg.sv
// One entry of the elastic stage: valid, late_ok, ctrl, data and late field.
//   clk, rst      clock, asynchronous active-low reset
//   clr           synchronous kill: valid/late_ok/ctrl cleared, payload held
//   ld            capture a new entry (wins over pop on the same slot)
//   pop           entry leaves the stage
//   ld_late       deferred late-field fill, sets late_ok
//   in_*          new entry fields
//   late_data     deferred late field
//   valid, late_ok, ctrl, data, late   stored entry
module pipe_stage_elastic_entry_reg #(
  parameter int DATA_W = 16,
  parameter int CTRL_W = 8,
  parameter int LATE_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              ld,
  input  logic              pop,
  input  logic              ld_late,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic [LATE_W-1:0] in_late,
  input  logic              in_late_ok,
  input  logic [LATE_W-1:0] late_data,
  output logic              valid,
  output logic              late_ok,
  output logic [CTRL_W-1:0] ctrl,
  output logic [DATA_W-1:0] data,
  output logic [LATE_W-1:0] late
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid   <= 1'b0;
      late_ok <= 1'b0;
      ctrl    <= '0;
      data    <= '0;
      late    <= '0;
    end else if (clr) begin
      valid   <= 1'b0;
      late_ok <= 1'b0;
      ctrl    <= '0;
    end else begin
      if (ld) begin
        valid   <= 1'b1;
        late_ok <= in_late_ok;
        ctrl    <= in_ctrl;
        data    <= in_data;
        late    <= in_late;
      end else if (pop) begin
        // ctrl is zeroed so a stale control vector never survives a bubble
        valid   <= 1'b0;
        late_ok <= 1'b0;
        ctrl    <= '0;
      end
      if (ld_late) begin
        late    <= late_data;
        late_ok <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline stage with valid/ready handshake, optional 2-entry skid
// buffer, synchronous flush and a late field filled after capture.
//   clk, rst                  clock, asynchronous active-low reset
//   flush                     kill all held entries (bubble insert)
//   in_valid/in_ready         upstream handshake
//   in_ctrl/in_data           control vector and early payload
//   in_late_vld/in_late       late field delivered with the entry
//   late_vld/late_data        deferred late field for the pending entry
//   out_valid/out_ready       downstream handshake (head valid and complete)
//   out_ctrl/out_data/out_late head entry, ctrl zero when !out_valid
//   err_late                  sticky: late_vld seen with nothing pending
module pipe_stage_elastic
  import pipe_stage_elastic_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int CTRL_W  = 8,
  parameter int LATE_W  = 16,
  parameter int SKID_EN = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_late_vld,
  input  logic [LATE_W-1:0] in_late,
  input  logic              late_vld,
  input  logic [LATE_W-1:0] late_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [LATE_W-1:0] out_late,
  output logic              err_late
);

  localparam int DEPTH = (SKID_EN != 0) ? SKID_DEPTH : 1;

  logic [1:0]        v, lok, ld, pop, ld_late;
  logic [CTRL_W-1:0] e_ctrl [2];
  logic [DATA_W-1:0] e_data [2];
  logic [LATE_W-1:0] e_late [2];

  logic   hd, tl, pend, pend_ptr, rdy_q, err_q;
  logic   acc, xfer, head_v, head_ok;
  logic   pend_nxt, ptr_nxt, rdy_d, err_set;
  count_t cnt, cnt_nxt;

  for (genvar g = 0; g < 2; g++) begin : g_slot
    if (g < DEPTH) begin : g_used
      pipe_stage_elastic_entry_reg #(
        .DATA_W(DATA_W), .CTRL_W(CTRL_W), .LATE_W(LATE_W)
      ) u_entry (
        .clk       (clk),
        .rst       (rst),
        .clr       (flush),
        .ld        (ld[g]),
        .pop       (pop[g]),
        .ld_late   (ld_late[g]),
        .in_ctrl   (in_ctrl),
        .in_data   (in_data),
        .in_late   (in_late),
        .in_late_ok(in_late_vld),
        .late_data (late_data),
        .valid     (v[g]),
        .late_ok   (lok[g]),
        .ctrl      (e_ctrl[g]),
        .data      (e_data[g]),
        .late      (e_late[g])
      );
    end else begin : g_unused
      assign v[g]      = 1'b0;
      assign lok[g]    = 1'b0;
      assign e_ctrl[g] = '0;
      assign e_data[g] = '0;
      assign e_late[g] = '0;
    end
  end

  always_comb begin
    head_v    = v[hd];
    head_ok   = lok[hd];
    out_valid = head_v & head_ok & ~flush;
    xfer      = out_valid & out_ready;
    // with the skid buffer in_ready comes straight from a flop
    in_ready  = (SKID_EN != 0) ? rdy_q : (~head_v | xfer);
    acc       = in_valid & in_ready & ~flush;
    // new entries go behind the head when one is held (single slot: same slot)
    tl        = ((SKID_EN != 0) && head_v) ? ~hd : hd;
    cnt       = {1'b0, v[0]} + {1'b0, v[1]};

    ld          = '0;
    ld[tl]      = acc;
    pop         = '0;
    pop[hd]     = xfer;
    ld_late     = '0;
    ld_late[pend_ptr] = late_vld & pend & ~flush;

    out_ctrl = out_valid ? e_ctrl[hd] : '0;
    out_data = e_data[hd];
    out_late = e_late[hd];

    err_set  = late_vld & ~pend & ~flush;
    ptr_nxt  = pend_ptr;
    pend_nxt = pend;
    if (flush) begin
      pend_nxt = 1'b0;
    end else if (late_vld && pend) begin
      pend_nxt = 1'b0;
    end else if (acc && !in_late_vld) begin
      pend_nxt = 1'b1;
      ptr_nxt  = tl;
    end

    cnt_nxt = flush ? count_t'(0) : count_next(cnt, acc, xfer);
    rdy_d   = (cnt_nxt != count_t'(SKID_DEPTH)) & ~pend_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hd       <= 1'b0;
      pend     <= 1'b0;
      pend_ptr <= 1'b0;
      rdy_q    <= 1'b1;
      err_q    <= 1'b0;
    end else begin
      pend     <= pend_nxt;
      pend_ptr <= ptr_nxt;
      rdy_q    <= rdy_d;
      err_q    <= err_q | err_set;
      if (flush) begin
        hd <= 1'b0;
      end else if (xfer && (SKID_EN != 0)) begin
        hd <= ~hd;
      end
    end
  end

  assign err_late = err_q;

endmodule

// File: tb/tb_pipe_stage_elastic.sv
module tb_pipe_stage_elastic;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_ctrl;
  logic [15:0] in_data;
  logic        in_late_vld;
  logic [15:0] in_late;
  logic        late_vld;
  logic [15:0] late_data;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_ctrl;
  logic [15:0] out_data;
  logic [15:0] out_late;
  logic        err_late;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pipe_stage_elastic #(
    .DATA_W(16), .CTRL_W(8), .LATE_W(16), .SKID_EN(1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_ctrl    (in_ctrl),
    .in_data    (in_data),
    .in_late_vld(in_late_vld),
    .in_late    (in_late),
    .late_vld   (late_vld),
    .late_data  (late_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_ctrl   (out_ctrl),
    .out_data   (out_data),
    .out_late   (out_late),
    .err_late   (err_late)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [15:0] d, input logic [7:0] c);
    in_valid = 1'b1; in_data = d; in_ctrl = c; in_late = d ^ 16'hA5A5; in_late_vld = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_ctrl = '0; in_data = '0;
    in_late_vld = 1'b0; in_late = '0; late_vld = 1'b0; late_data = '0; out_ready = 1'b0;
    repeat (2) tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_ctrl", out_ctrl, 0);
    chk("rst_err_late", err_late, 0);
    rst = 1'b1;
    tick();
    chk("rel_in_ready", in_ready, 1);
    chk("rel_out_valid", out_valid, 0);

    // streaming: one entry per cycle, visible the cycle after capture
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_late_vld = 1'b1;
      in_data = 16'(i + 1); in_ctrl = 8'(8'h10 + i); in_late = 16'(16'h0100 + i);
      tick();
      chk("stream_valid", out_valid, 1);
      chk("stream_data", out_data, 32'(i + 1));
      chk("stream_ctrl", out_ctrl, 32'(8'h10 + i));
      chk("stream_late", out_late, 32'(16'h0100 + i));
      chk("stream_ready", in_ready, 1);
    end
    in_valid = 1'b0;
    tick();
    chk("stream_drain_valid", out_valid, 0);
    chk("stream_drain_ctrl", out_ctrl, 0);

    // backpressure: two held, third waits for a freed slot
    out_ready = 1'b0;
    in_valid = 1'b1; in_late_vld = 1'b1; in_data = 16'h0001; in_ctrl = 8'h31;
    tick();
    chk("bp_ready_1", in_ready, 1);
    chk("bp_head_1", out_data, 16'h0001);
    in_data = 16'h0002; in_ctrl = 8'h32;
    tick();
    chk("bp_ready_full", in_ready, 0);
    in_data = 16'h0003; in_ctrl = 8'h33;
    tick();
    chk("bp_ready_still_full", in_ready, 0);
    chk("bp_head_hold", out_data, 16'h0001);
    chk("bp_valid_hold", out_valid, 1);
    out_ready = 1'b1;
    tick();
    chk("bp_head_2", out_data, 16'h0002);
    chk("bp_ready_freed", in_ready, 1);
    tick();
    chk("bp_head_3", out_data, 16'h0003);
    chk("bp_ctrl_3", out_ctrl, 8'h33);
    in_valid = 1'b0;
    tick();
    chk("bp_empty", out_valid, 0);

    // late fill of a pending entry
    in_valid = 1'b1; in_late_vld = 1'b0; in_ctrl = 8'h81; in_data = 16'h0044; in_late = 16'h1111;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("late_wait_valid", out_valid, 0);
      chk("late_wait_ready", in_ready, 0);
      chk("late_wait_ctrl", out_ctrl, 0);
      tick();
    end
    late_vld = 1'b1; late_data = 16'hBEEF;
    tick();
    late_vld = 1'b0;
    chk("late_out_valid", out_valid, 1);
    chk("late_out_late", out_late, 16'hBEEF);
    chk("late_out_ctrl", out_ctrl, 8'h81);
    chk("late_out_data", out_data, 16'h0044);
    chk("late_in_ready", in_ready, 1);
    chk("late_no_err", err_late, 0);
    tick();
    chk("late_drained", out_valid, 0);

    // flush with two held plus late_vld and in_valid in the flush cycle
    out_ready = 1'b0;
    push(16'h000A, 8'h11);
    push(16'h000B, 8'h22);
    chk("fl_pre_valid", out_valid, 1);
    out_ready = 1'b1; flush = 1'b1; late_vld = 1'b1;
    in_valid = 1'b1; in_data = 16'h00CC; in_ctrl = 8'h44; in_late_vld = 1'b1;
    #1;
    chk("fl_cycle_valid", out_valid, 0);
    chk("fl_cycle_ctrl", out_ctrl, 0);
    tick();
    flush = 1'b0; late_vld = 1'b0; in_valid = 1'b0;
    #1;
    chk("fl_after_valid", out_valid, 0);
    chk("fl_after_ctrl", out_ctrl, 0);
    chk("fl_after_err", err_late, 0);
    chk("fl_after_ready", in_ready, 1);
    tick();
    chk("fl_nothing_accepted", out_valid, 0);

    // spurious late_vld on an empty stage
    late_vld = 1'b1; late_data = 16'h5555;
    tick();
    late_vld = 1'b0;
    chk("err_set", err_late, 1);
    repeat (3) tick();
    chk("err_sticky", err_late, 1);

    // reset mid-stream with two entries held
    out_ready = 1'b0;
    push(16'h0021, 8'h55);
    push(16'h0022, 8'h66);
    chk("mid_pre_valid", out_valid, 1);
    chk("mid_pre_ready", in_ready, 0);
    rst = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_ctrl", out_ctrl, 0);
    chk("mid_rst_err", err_late, 0);
    tick();
    rst = 1'b1;
    tick();
    chk("mid_rel_ready", in_ready, 1);
    chk("mid_rel_valid", out_valid, 0);
    chk("mid_rel_data", out_data, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
